// File: rtl/pwm_gen8_if.sv
// PWM control bus: count enable, PERIOD/DUTY load handshake and the PWM/WRAP outputs.
// Names are from the generator's point of view; the generator uses the slave modport.
interface pwm_gen8_if #(
   parameter int N = 8
);
   logic         i_ce;
   logic         i_load_valid;
   logic         o_load_ready;
   logic [N-1:0] i_period;
   logic [N-1:0] i_duty;
   logic         o_pwm;
   logic         o_wrap;

   modport master (
      output i_ce,
      output i_load_valid,
      output i_period,
      output i_duty,
      input  o_load_ready,
      input  o_pwm,
      input  o_wrap
   );

   modport slave (
      input  i_ce,
      input  i_load_valid,
      input  i_period,
      input  i_duty,
      output o_load_ready,
      output o_pwm,
      output o_wrap
   );
endinterface

// File: rtl/pwm_gen8.sv
// 8-bit PWM generator: free-running counter with UGE compares; PERIOD/DUTY reloads pass
// through a one-deep shadow (ready = shadow empty) and apply only at the period wrap.
module pwm_gen8 #(
   parameter int           N          = 8,
   parameter logic [N-1:0] PERIOD_RST = 8'hFF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   pwm_gen8_if.slave  io_pwm
);

   // a >= b as the carry-out of a + ~b + 1, rippled LSB first.
   function automatic logic uge(input logic [N-1:0] a, input logic [N-1:0] b);
      logic c;
      c = 1'b1;
      for (int i = 0; i < N; i++) begin
         c = (a[i] & ~b[i]) | ((a[i] | ~b[i]) & c);
      end
      return c;
   endfunction

   logic [N-1:0] r_count;
   logic [N-1:0] r_per_a;
   logic [N-1:0] r_duty_a;
   logic [N-1:0] r_per_s;
   logic [N-1:0] r_duty_s;
   logic         r_pending;
   logic         r_wrap_q;

   logic         w_end_hit;
   logic         w_lvl;
   logic         w_accept;
   logic [N-1:0] w_count_inc;

   assign w_end_hit   = uge(r_count, r_per_a);
   assign w_lvl       = ~uge(r_count, r_duty_a);
   assign w_accept    = io_pwm.i_load_valid & ~r_pending;
   assign w_count_inc = r_count + {{(N-1){1'b0}}, 1'b1};

   assign io_pwm.o_pwm        = w_lvl;
   assign io_pwm.o_load_ready = ~r_pending;
   assign io_pwm.o_wrap       = r_wrap_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count   <= '0;
         r_per_a   <= PERIOD_RST;
         r_duty_a  <= '0;
         r_per_s   <= '0;
         r_duty_s  <= '0;
         r_pending <= 1'b0;
         r_wrap_q  <= 1'b0;
      end else begin
         // Accept needs an empty shadow, so it never coincides with a transfer.
         if (w_accept) begin
            r_per_s   <= io_pwm.i_period;
            r_duty_s  <= io_pwm.i_duty;
            r_pending <= 1'b1;
         end
         if (io_pwm.i_ce) begin
            if (w_end_hit) begin
               r_count  <= '0;
               r_wrap_q <= 1'b1;
               if (r_pending) begin
                  r_per_a   <= r_per_s;
                  r_duty_a  <= r_duty_s;
                  r_pending <= 1'b0;
               end
            end else begin
               r_count  <= w_count_inc;
               r_wrap_q <= 1'b0;
            end
         end else begin
            r_wrap_q <= 1'b0;
         end
      end
   end

endmodule
